// File: rtl/z16_seq_ctrl.sv
// Multi-cycle sequencer for the z16 core: fetch, decode, execute, memory, write-back.
// Optional halt instruction (opcode 4'hF) enabled by defining Z16_HALT_EN.
module z16_seq_ctrl #(
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_imem_ack,
    input  logic [15:0] i_imem_rdata,
    input  logic        i_dmem_ack,
    output logic [15:0] o_pc,
    output logic        o_imem_req,
    output logic [15:0] o_ir,
    output logic        o_dmem_req,
    output logic        o_dmem_we,
    output logic        o_rf_we,
    output logic        o_retire,
    output logic [2:0]  o_state,
    output logic        o_halted
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5
    } state_t;

    // Handshake: a request is held high from state entry until its ack is seen;
    // an ack arriving in any other state is ignored.
    state_t      state_q, state_d;
    logic [15:0] pc_q, pc_d;
    logic [15:0] ir_q, ir_d;
    logic        retire_q, retire_d;
    logic [3:0]  opcode;
    logic        is_load, is_store;

    assign opcode   = ir_q[3:0];
    assign is_load  = (opcode == 4'hA);
    assign is_store = (opcode == 4'hB);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q  <= S_FETCH;
            pc_q     <= RESET_PC;
            ir_q     <= 16'h0000;
            retire_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            ir_q     <= ir_d;
            retire_q <= retire_d;
        end
    end

    // Retire is registered so it pulses in the cycle after the completing edge.
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        ir_d     = ir_q;
        retire_d = 1'b0;
        case (state_q)
            S_FETCH: begin
                if (i_imem_ack) begin
                    ir_d    = i_imem_rdata;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: state_d = S_EXEC;
            S_EXEC: begin
                if (is_load || is_store) begin
                    state_d = S_MEM;
`ifdef Z16_HALT_EN
                end else if (opcode == 4'hF) begin
                    state_d  = S_HALT;
                    retire_d = 1'b1;
`endif
                end else begin
                    state_d = S_WB;
                end
            end
            S_MEM: begin
                if (i_dmem_ack) begin
                    if (is_store) begin
                        state_d  = S_FETCH;
                        pc_d     = pc_q + 16'd2;
                        retire_d = 1'b1;
                    end else begin
                        state_d = S_WB;
                    end
                end
            end
            S_WB: begin
                state_d  = S_FETCH;
                pc_d     = pc_q + 16'd2;
                retire_d = 1'b1;
            end
            S_HALT: state_d = S_HALT;
            default: state_d = S_FETCH;
        endcase
    end

    always_comb begin
        o_imem_req = (state_q == S_FETCH);
        o_dmem_req = (state_q == S_MEM);
        o_dmem_we  = (state_q == S_MEM) && is_store;
        o_rf_we    = (state_q == S_WB);
    end

    assign o_pc     = pc_q;
    assign o_ir     = ir_q;
    assign o_retire = retire_q;
    assign o_state  = state_q;

`ifdef Z16_HALT_EN
    assign o_halted = (state_q == S_HALT);
`else
    assign o_halted = 1'b0;
`endif

endmodule

// File: tb/tb_z16_seq_ctrl.sv
// Directed bench for z16_seq_ctrl: vector table for a full ALU/load/store program,
// plus hand sequences for stall, wrap, async reset mid-access and halt.
module tb_z16_seq_ctrl;

    logic        i_clk;
    logic        i_rst_n;
    logic        i_imem_ack;
    logic [15:0] i_imem_rdata;
    logic        i_dmem_ack;

    logic [15:0] o_pc, o_ir, w_pc, w_ir;
    logic        o_imem_req, o_dmem_req, o_dmem_we, o_rf_we, o_retire, o_halted;
    logic        w_imem_req, w_dmem_req, w_dmem_we, w_rf_we, w_retire, w_halted;
    logic [2:0]  o_state, w_state;

    int n_checks = 0;
    int n_fail   = 0;

    z16_seq_ctrl dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n),
        .i_imem_ack(i_imem_ack), .i_imem_rdata(i_imem_rdata), .i_dmem_ack(i_dmem_ack),
        .o_pc(o_pc), .o_imem_req(o_imem_req), .o_ir(o_ir),
        .o_dmem_req(o_dmem_req), .o_dmem_we(o_dmem_we), .o_rf_we(o_rf_we),
        .o_retire(o_retire), .o_state(o_state), .o_halted(o_halted)
    );

    z16_seq_ctrl #(.RESET_PC(16'hFFFE)) dut_wrap (
        .i_clk(i_clk), .i_rst_n(i_rst_n),
        .i_imem_ack(i_imem_ack), .i_imem_rdata(i_imem_rdata), .i_dmem_ack(i_dmem_ack),
        .o_pc(w_pc), .o_imem_req(w_imem_req), .o_ir(w_ir),
        .o_dmem_req(w_dmem_req), .o_dmem_we(w_dmem_we), .o_rf_we(w_rf_we),
        .o_retire(w_retire), .o_state(w_state), .o_halted(w_halted)
    );

    // clock / reset
    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic do_reset();
        i_rst_n      = 1'b0;
        i_imem_ack   = 1'b0;
        i_imem_rdata = 16'h0000;
        i_dmem_ack   = 1'b0;
        repeat (2) @(negedge i_clk);
        i_rst_n = 1'b1;
    endtask

    task automatic drive(input logic ia, input logic [15:0] rd, input logic da);
        i_imem_ack   = ia;
        i_imem_rdata = rd;
        i_dmem_ack   = da;
    endtask

    // flags = {imem_req, dmem_req, dmem_we, rf_we, retire}
    typedef struct {
        logic        ia;
        logic [15:0] rd;
        logic        da;
        logic [2:0]  st;
        logic [15:0] pc;
        logic [15:0] ir;
        logic [4:0]  fl;
    } vec_t;

    vec_t vecs[19];

    initial begin
        vecs[0]  = '{1'b1, 16'h1230, 1'b0, 3'd0, 16'h0000, 16'h0000, 5'b10000};
        vecs[1]  = '{1'b0, 16'h0000, 1'b0, 3'd1, 16'h0000, 16'h1230, 5'b00000};
        vecs[2]  = '{1'b1, 16'hBEEF, 1'b1, 3'd2, 16'h0000, 16'h1230, 5'b00000};
        vecs[3]  = '{1'b0, 16'h0000, 1'b0, 3'd4, 16'h0000, 16'h1230, 5'b00010};
        vecs[4]  = '{1'b1, 16'h321A, 1'b0, 3'd0, 16'h0002, 16'h1230, 5'b10001};
        vecs[5]  = '{1'b0, 16'h0000, 1'b0, 3'd1, 16'h0002, 16'h321A, 5'b00000};
        vecs[6]  = '{1'b0, 16'h0000, 1'b0, 3'd2, 16'h0002, 16'h321A, 5'b00000};
        vecs[7]  = '{1'b1, 16'hDEAD, 1'b0, 3'd3, 16'h0002, 16'h321A, 5'b01000};
        vecs[8]  = '{1'b0, 16'h0000, 1'b0, 3'd3, 16'h0002, 16'h321A, 5'b01000};
        vecs[9]  = '{1'b0, 16'h0000, 1'b1, 3'd3, 16'h0002, 16'h321A, 5'b01000};
        vecs[10] = '{1'b0, 16'h0000, 1'b0, 3'd4, 16'h0002, 16'h321A, 5'b00010};
        vecs[11] = '{1'b1, 16'h456B, 1'b0, 3'd0, 16'h0004, 16'h321A, 5'b10001};
        vecs[12] = '{1'b0, 16'h0000, 1'b1, 3'd1, 16'h0004, 16'h456B, 5'b00000};
        vecs[13] = '{1'b0, 16'h0000, 1'b0, 3'd2, 16'h0004, 16'h456B, 5'b00000};
        vecs[14] = '{1'b0, 16'h0000, 1'b0, 3'd3, 16'h0004, 16'h456B, 5'b01100};
        vecs[15] = '{1'b0, 16'h0000, 1'b0, 3'd3, 16'h0004, 16'h456B, 5'b01100};
        vecs[16] = '{1'b0, 16'h0000, 1'b1, 3'd3, 16'h0004, 16'h456B, 5'b01100};
        vecs[17] = '{1'b0, 16'h0000, 1'b0, 3'd0, 16'h0006, 16'h456B, 5'b10001};
        vecs[18] = '{1'b0, 16'h0000, 1'b0, 3'd0, 16'h0006, 16'h456B, 5'b10000};

        // asynchronous reset values, checked without a clock edge
        i_rst_n = 1'b1;
        drive(1'b0, 16'h0000, 1'b0);
        @(negedge i_clk);
        #2 i_rst_n = 1'b0;
        #1;
        check("rst_state", {13'd0, o_state}, 16'd0);
        check("rst_pc", o_pc, 16'h0000);
        check("rst_wrap_pc", w_pc, 16'hFFFE);
        check("rst_ir", o_ir, 16'h0000);
        check("rst_flags", {11'd0, o_imem_req, o_dmem_req, o_dmem_we, o_rf_we, o_retire}, 16'b10000);
        check("rst_halted", {15'd0, o_halted}, 16'd0);

        // fetch stall: no ack for 5 cycles
        do_reset();
        for (int c = 0; c < 5; c++) begin
            check("stall_state", {13'd0, o_state}, 16'd0);
            check("stall_imem_req", {15'd0, o_imem_req}, 16'd1);
            check("stall_pc", o_pc, 16'h0000);
            @(negedge i_clk);
        end
        check("stall_ir", o_ir, 16'h0000);

        // program: ALU, load (2 waits), store (2 waits) with stray acks
        do_reset();
        for (int i = 0; i < 19; i++) begin
            check($sformatf("vec%0d_state", i), {13'd0, o_state}, {13'd0, vecs[i].st});
            check($sformatf("vec%0d_pc", i), o_pc, vecs[i].pc);
            check($sformatf("vec%0d_ir", i), o_ir, vecs[i].ir);
            check($sformatf("vec%0d_flags", i),
                  {11'd0, o_imem_req, o_dmem_req, o_dmem_we, o_rf_we, o_retire},
                  {11'd0, vecs[i].fl});
            drive(vecs[i].ia, vecs[i].rd, vecs[i].da);
            @(negedge i_clk);
        end

        // PC wrap: RESET_PC = FFFE, one ALU instruction
        do_reset();
        drive(1'b1, 16'h1230, 1'b0);
        @(negedge i_clk);
        drive(1'b0, 16'h0000, 1'b0);
        repeat (2) @(negedge i_clk);
        check("wrap_rf_we", {15'd0, w_rf_we}, 16'd1);
        check("wrap_pc_before", w_pc, 16'hFFFE);
        @(negedge i_clk);
        check("wrap_pc_after", w_pc, 16'h0000);
        check("wrap_retire", {15'd0, w_retire}, 16'd1);
        check("wrap_ref_pc", o_pc, 16'h0002);

        // reset asserted during a store wait
        do_reset();
        drive(1'b1, 16'h000B, 1'b0);
        @(negedge i_clk);
        drive(1'b0, 16'h0000, 1'b0);
        repeat (2) @(negedge i_clk);
        check("mem_abort_req_pre", {14'd0, o_dmem_req, o_dmem_we}, 16'b11);
        @(negedge i_clk);
        #2 i_rst_n = 1'b0;
        #1;
        check("mem_abort_dmem", {14'd0, o_dmem_req, o_dmem_we}, 16'b00);
        check("mem_abort_state", {13'd0, o_state}, 16'd0);
        check("mem_abort_pc", o_pc, 16'h0000);
        check("mem_abort_retire", {15'd0, o_retire}, 16'd0);
        check("mem_abort_ir", o_ir, 16'h0000);
        i_dmem_ack = 1'b1;
        @(negedge i_clk);
        i_dmem_ack = 1'b0;
        i_rst_n = 1'b1;
        check("post_rst_pc", o_pc, 16'h0000);
        check("post_rst_imem_req", {15'd0, o_imem_req}, 16'd1);
        check("post_rst_retire", {15'd0, o_retire}, 16'd0);
        @(negedge i_clk);
        check("post_rst_state", {13'd0, o_state}, 16'd0);

        // opcode F: halt when enabled, ordinary ALU otherwise
        do_reset();
        drive(1'b1, 16'h000F, 1'b0);
        @(negedge i_clk);
        drive(1'b0, 16'h0000, 1'b0);
        repeat (2) @(negedge i_clk);
`ifdef Z16_HALT_EN
        check("halt_state", {13'd0, o_state}, 16'd5);
        check("halt_halted", {15'd0, o_halted}, 16'd1);
        check("halt_retire", {15'd0, o_retire}, 16'd1);
        check("halt_pc", o_pc, 16'h0000);
        drive(1'b1, 16'h1234, 1'b1);
        repeat (3) @(negedge i_clk);
        check("halt_hold_state", {13'd0, o_state}, 16'd5);
        check("halt_hold_flags", {11'd0, o_imem_req, o_dmem_req, o_dmem_we, o_rf_we, o_retire}, 16'b00000);
        check("halt_hold_ir", o_ir, 16'h000F);
        check("halt_hold_pc", o_pc, 16'h0000);
        check("halt_hold_halted", {15'd0, o_halted}, 16'd1);
`else
        check("noh_state", {13'd0, o_state}, 16'd4);
        check("noh_rf_we", {15'd0, o_rf_we}, 16'd1);
        check("noh_halted", {15'd0, o_halted}, 16'd0);
        @(negedge i_clk);
        check("noh_state_after", {13'd0, o_state}, 16'd0);
        check("noh_pc", o_pc, 16'h0002);
        check("noh_retire", {15'd0, o_retire}, 16'd1);
        check("noh_halted_after", {15'd0, o_halted}, 16'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
